apb_arbiter_master: RTL

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

---
 rtl/apb_arbiter_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/apb_arbiter_master.sv
// APB master shared by two requesters with round-robin arbitration.
// Each requester holds req until its one-cycle done pulse. One transfer
// runs at a time: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
// Optional ACCESS wait timeout: define APB_TIMEOUT_EN.
module apb_arbiter_master #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_0,
  input  logic              wr_0,
  input  logic [AWIDTH-1:0] addr_0,
  input  logic [DWIDTH-1:0] wdata_0,
  input  logic              req_1,
  input  logic              wr_1,
  input  logic [AWIDTH-1:0] addr_1,
  input  logic [DWIDTH-1:0] wdata_1,
  output logic              done_0,
  output logic              done_1,
  output logic [DWIDTH-1:0] rdata,
  output logic              rerr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [AWIDTH-1:0] paddr,
  output logic [DWIDTH-1:0] pwdata,
  input  logic              pready,
  input  logic [DWIDTH-1:0] prdata,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Elaboration guard on the timeout range
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_arbiter_master: TIMEOUT must be in 1..255");
  end

  state_e state_q, state_d;

  logic              last_q, last_d;       // 1 = requester 1 was granted last
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;

  logic grant_c;      // a grant is issued this cycle
  logic pick1_c;      // the grant goes to requester 1
  logic complete_c;   // slave completes the access this cycle
  logic timeout_c;    // access aborted by the wait limit this cycle

  // Round-robin pick: a lone request wins, a tie goes to the one not served last
  always_comb begin
    grant_c    = (state_q == S_IDLE) && (req_0 || req_1);
    pick1_c    = req_1 && (!req_0 || !last_q);
    complete_c = (state_q == S_ACCESS) && pready;
  end

`ifdef APB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Count ACCESS wait cycles; cleared on each new grant
  always_comb begin
    cnt_d     = cnt_q;
    timeout_c = 1'b0;
    if (grant_c) begin
      cnt_d = 8'd0;
    end else if ((state_q == S_ACCESS) && !pready) begin
      cnt_d     = cnt_q + 8'd1;
      timeout_c = (9'({1'b0, cnt_q}) + 9'd1) == 9'(TIMEOUT);
    end
  end

  // Wait counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_0 || req_1) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || timeout_c) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values, registered below
  always_comb begin
    last_d    = last_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    done0_d   = 1'b0;
    done1_d   = 1'b0;

    if (grant_c) begin
      last_d   = pick1_c;
      pwrite_d = pick1_c ? wr_1    : wr_0;
      paddr_d  = pick1_c ? addr_1  : addr_0;
      pwdata_d = pick1_c ? wdata_1 : wdata_0;
    end

    if (complete_c) begin
      rerr_d = pslverr;
      if (!pwrite_q) rdata_d = prdata;
    end else if (timeout_c) begin
      rerr_d = 1'b1;
    end

    if (state_d == S_DONE) begin
      done0_d = !last_q;
      done1_d = last_q;
    end
  end

  // Output and datapath registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_q    <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign rdata   = rdata_q;
  assign rerr    = rerr_q;
  assign done_0  = done0_q;
  assign done_1  = done1_q;

endmodule
